// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Pipelined 8-function bitwise logic unit with valid/ready
//            handshakes, registered reduction flags and a saturating
//            count of completed results.
// Revision : 1.0
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [2:0] C_OP_AND    = 3'd0;
    localparam logic [2:0] C_OP_OR     = 3'd1;
    localparam logic [2:0] C_OP_XOR    = 3'd2;
    localparam logic [2:0] C_OP_NAND   = 3'd3;
    localparam logic [2:0] C_OP_NOR    = 3'd4;
    localparam logic [2:0] C_OP_XNOR   = 3'd5;
    localparam logic [2:0] C_OP_ANDNOT = 3'd6;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] all_q, all_d;
    logic [STAGES-1:0] any_q, any_d;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_res;
    logic              w_out_hs;

    always_comb begin
        w_res = a;
        case (op)
            C_OP_AND:    w_res = a & b;
            C_OP_OR:     w_res = a | b;
            C_OP_XOR:    w_res = a ^ b;
            C_OP_NAND:   w_res = ~(a & b);
            C_OP_NOR:    w_res = ~(a | b);
            C_OP_XNOR:   w_res = ~(a ^ b);
            C_OP_ANDNOT: w_res = a & ~b;
            default:     w_res = a;
        endcase
    end

    // A stage may load when it is empty or its own contents leave this
    // cycle; walking from the output back makes bubbles never block.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = !vld_q[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_load[i] = !vld_q[i] || w_load[i+1];
        end
    end

    assign in_ready = w_load[0] && !rst;
    assign w_out_hs = vld_q[STAGES-1] && out_ready;

    always_comb begin
        vld_d = vld_q;
        all_d = all_q;
        any_d = any_q;
        dat_d = dat_q;
        if (w_load[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                dat_d[0] = w_res;
                all_d[0] = &w_res;
                any_d[0] = |w_res;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (w_load[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                    all_d[i] = all_q[i-1];
                    any_d[i] = any_q[i-1];
                end
            end
        end
    end

    // Clear takes priority over a same-cycle completion.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (w_out_hs && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            all_q <= '0;
            any_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            all_q <= all_d;
            any_q <= any_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign y         = dat_q[STAGES-1];
    assign y_all     = all_q[STAGES-1];
    assign y_any     = any_q[STAGES-1];
    assign txn_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Self-checking bench for logic_unit_pipe (WIDTH=8, STAGES=2,
//            CNT_W=4) using a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_all;
    logic             y_any;
    logic             cnt_clr;
    logic [CNT_W-1:0] txn_count;

    logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_all     (y_all),
        .y_any     (y_any),
        .cnt_clr   (cnt_clr),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             t;
        logic [WIDTH-1:0] y;
    } item_t;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic             all;
        logic             any;
    } vec_t;

    item_t      q[$];
    logic [9:0] got[$];
    vec_t       tbl[10];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         m_cnt   = 0;

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return x & ~z;
            default: return x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check the DUT against the model, then
    // advance the model by what the coming rising edge will do.
    task automatic step(input bit iv, input logic [2:0] o, input logic [WIDTH-1:0] ia,
                        input logic [WIDTH-1:0] ib, input bit ordy, input bit clr,
                        output bit acc);
        bit exp_ir;
        bit exp_ov;
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        exp_ir = (q.size() < STAGES) || ordy;
        exp_ov = (q.size() > 0) && ((cyc - q[0].t) >= STAGES);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            check("y", {24'd0, y}, {24'd0, q[0].y});
            check("y_all", {31'd0, y_all}, {31'd0, (q[0].y == 8'hFF)});
            check("y_any", {31'd0, y_any}, {31'd0, (q[0].y != 8'h00)});
        end
        check("txn_count", {28'd0, txn_count}, m_cnt);
        if (exp_ov && ordy) begin
            got.push_back({y_all, y_any, y});
            void'(q.pop_front());
        end
        if (clr) m_cnt = 0;
        else if (exp_ov && ordy && m_cnt != CNT_MAX) m_cnt++;
        acc = iv && exp_ir;
        if (acc) q.push_back('{t: cyc, y: ref_op(o, ia, ib)});
        cyc++;
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               acc;
        int               k;
        int               bp_acc;
        int               guard;
        logic [2:0]       io[5];
        logic [WIDTH-1:0] ia[5];
        logic [WIDTH-1:0] ib[5];

        tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b1};
        tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b1};
        tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'h30, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0, 1'b0, 1'b1};
        tbl[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
        tbl[9] = '{3'd2, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_y", {24'd0, y}, 0);
        check("rst_flags", {30'd0, y_all, y_any}, 0);
        check("rst_txn_count", {28'd0, txn_count}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Truth table and reductions streamed back to back.
        got.delete();
        for (int i = 0; i < 10; i++) step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, 1'b0, acc);
        drain(4);
        check("tbl_count", got.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                check("tbl_y", {24'd0, got[i][7:0]}, {24'd0, tbl[i].y});
                check("tbl_y_all", {31'd0, got[i][9]}, {31'd0, tbl[i].all});
                check("tbl_y_any", {31'd0, got[i][8]}, {31'd0, tbl[i].any});
            end
        end

        // Latency and throughput.
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, acc);
        drain(4);
        check("lat_txn_count", {28'd0, txn_count}, 4);

        // Backpressure: five offered with the consumer stalled.
        for (int i = 0; i < 5; i++) begin
            io[i] = 3'($urandom_range(7)); ia[i] = 8'($urandom); ib[i] = 8'($urandom);
        end
        got.delete();
        k = 0; bp_acc = 0;
        repeat (12) begin
            step(1'b1, io[k], ia[k], ib[k], 1'b0, 1'b0, acc);
            if (acc) begin k++; bp_acc++; end
        end
        check("bp_accepted", bp_acc, 2);
        guard = 0;
        while (k < 5 && guard < 50) begin
            step(1'b1, io[k], ia[k], ib[k], 1'b1, 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        check("bp_all_accepted", k, 5);
        drain(4);
        check("bp_delivered", got.size(), 5);

        // Counter saturation, then clear racing a handshake.
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 17; i++)
            step(1'b1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, acc);
        drain(4);
        check("sat_txn_count", {28'd0, txn_count}, 15);
        step(1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        check("clr_txn_count", {28'd0, txn_count}, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(9) < 7, 3'($urandom_range(7)), 8'($urandom), 8'($urandom),
                 $urandom_range(9) < 6, $urandom_range(99) < 3, acc);
        drain(4);

        // Asynchronous reset with a full, stalled pipe.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 8'h11, 8'h22, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b1, 3'd7, 8'hA5, 8'h00, 1'b0, 1'b0, acc);
        @(negedge clk);
        #2;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_y", {24'd0, y}, 0);
        check("arst_txn_count", {28'd0, txn_count}, 0);
        check("arst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        check("arst_in_ready_held", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        q.delete(); got.delete(); m_cnt = 0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 1);
        step(1'b1, 3'd0, 8'h0F, 8'hFF, 1'b1, 1'b0, acc);
        drain(4);
        check("post_rst_count", got.size(), 1);
        if (got.size() > 0) check("post_rst_y", {24'd0, got[0][7:0]}, 32'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the successor to the single-bit two-input gate. It applies one of eight bitwise operations to two WIDTH-bit operands. Results pass through a STAGES-deep valid/ready pipeline with full backpressure. It also produces registered reduction flags and a saturating count of completed results. It sits between an operand producer and a result consumer, and both sides use valid/ready handshakes.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- STAGES, 2, pipeline depth in register stages (1..4)
- CNT_W, 16, width of the completed-result counter (≥2)

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  unit can accept operands this cycle
- op  input  3  operation select, sampled with operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- y  output  WIDTH  result
- y_all  output  1  AND-reduction of y
- y_any  output  1  OR-reduction of y
- cnt_clr  input  1  synchronous clear of txn_count
- txn_count  output  CNT_W  number of completed output handshakes, saturating

## Operation
- One clock. Reset is asynchronous and active-high.
- op encoding:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XNOR: ~(a^b)
  - 6 ANDNOT: a&~b
  - 7 PASS: a
- The result and both reductions are computed from a, b and op at input acceptance. They are written into stage 1 together.
- Each stage holds {valid, y, y_all, y_any}. Stage STAGES drives the outputs directly.
- Input handshake: accept when in_valid && in_ready at a rising edge.
- Output handshake: complete when out_valid && out_ready at a rising edge.
- Stage advance rule:
  - Stage i loads from stage i-1 when stage i is empty, or when stage i's contents are moving downstream in the same cycle.
  - Stage STAGES moves when out_ready is high.
  - Bubbles collapse: an empty stage never blocks upstream.
- in_ready = (stage 1 empty) or (stage 1 moving this cycle). It is combinational through the stage chain from out_ready. It is forced 0 while rst is high.
- Ordering: results emerge in acceptance order, with no loss and no duplication.
- Stall: while out_valid && !out_ready, y, y_all and y_any hold stable.
- Counter:
  - txn_count increments by 1 on each output handshake.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr sets it to 0 at the next edge. If cnt_clr and a handshake occur in the same cycle, clear wins and the result is 0.
- Reset values: all stage valids 0, out_valid 0, y 0, y_all 0, y_any 0, txn_count 0.
- Reset mid-operation discards all in-flight results without producing handshakes. After reset deasserts, in_ready is 1 in the first cycle.

## Timing
- Latency: operands accepted at edge t appear on the outputs after edge t+STAGES−1, when no stall occurs.
  - STAGES=1: the result is visible in the cycle right after acceptance.
  - STAGES=2: the result is visible one cycle later than that.
- Throughput: one result per cycle when in_valid and out_ready are held high.
- Capacity: with out_ready held low, exactly STAGES results are accepted. in_ready then drops to 0 in the cycle after the STAGES-th acceptance.
- When out_ready rises against a full pipe, in_ready rises in the same cycle, combinationally.
- txn_count updates at the edge of the handshake and is visible in the following cycle.
- No combinational path from a, b or op to any output.

## Test plan
- Truth table, WIDTH=8, STAGES=2: a=8'hF0, b=8'hCC, op=0..7 streamed with out_ready=1 → y = C0, FC, 3C, 3F, 03, C3, 30, F0 in order.
  - y_any=1 for all eight results.
  - y_all=0 for all eight results.
- Reductions: a=8'hFF, b=8'hFF, op=0 → y=FF, y_all=1. Then op=2 → y=00, y_any=0, y_all=0.
- Latency/throughput: 4 back-to-back accepts at edges t..t+3 with out_ready=1 → out_valid high in the 4 cycles following edges t+1..t+4. Results on consecutive cycles; txn_count reaches 4.
- Backpressure:
  - out_ready=0 with 5 offered inputs → exactly 2 accepted, then in_ready=0, and y holds the first result unchanged for 10 cycles.
  - Then out_ready=1 → all 5 results delivered in order, with no gaps after the pipe refills.
- Counter, CNT_W=4: 17 handshakes → txn_count=15, held.
  - cnt_clr asserted in the same cycle as a handshake → txn_count=0 next cycle.
- Reset mid-operation: assert rst asynchronously, between edges, with the pipe full and stalled → out_valid, y and txn_count read 0 immediately, and in_ready=0 while reset is held.
  - After release, in_ready=1.
  - A new input a=8'h0F, b=8'hFF, op=0 yields y=0F after the normal latency.
